// File: rtl/trigger_sequencer.sv
// Acquisition trigger sequencer: ARM/CAPTURE/GAP record timing over reps x hops,
// driven from a configuration snapshot taken when a run is accepted.
module trigger_sequencer #(
  parameter int CNT_WIDTH  = 25,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_active_low,
  input  logic [CNT_WIDTH-1:0] trigger_repetitions,
  input  logic [CNT_WIDTH-1:0] trigger_samples,
  input  logic [CNT_WIDTH-1:0] trig_generator_hops,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sample_valid,
  output logic                 trigger,
  output logic                 record_active,
  output logic [CNT_WIDTH-1:0] sample_index,
  output logic [CNT_WIDTH-1:0] rep_index,
  output logic [CNT_WIDTH-1:0] hop_index,
  output logic                 hop_advance,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] reps_q, reps_d;
  logic [CNT_WIDTH-1:0] samples_q, samples_d;
  logic [CNT_WIDTH-1:0] hops_q, hops_d;
  logic [CNT_WIDTH-1:0] sidx_q, sidx_d;
  logic [CNT_WIDTH-1:0] ridx_q, ridx_d;
  logic [CNT_WIDTH-1:0] hidx_q, hidx_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic                 hadv_q, hadv_d;
  logic                 cfgerr_q, cfgerr_d;

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q   <= S_IDLE;
      reps_q    <= '0;
      samples_q <= '0;
      hops_q    <= '0;
      sidx_q    <= '0;
      ridx_q    <= '0;
      hidx_q    <= '0;
      gap_q     <= '0;
      hadv_q    <= 1'b0;
      cfgerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      reps_q    <= reps_d;
      samples_q <= samples_d;
      hops_q    <= hops_d;
      sidx_q    <= sidx_d;
      ridx_q    <= ridx_d;
      hidx_q    <= hidx_d;
      gap_q     <= gap_d;
      hadv_q    <= hadv_d;
      cfgerr_q  <= cfgerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reps_d    = reps_q;
    samples_d = samples_q;
    hops_d    = hops_q;
    sidx_d    = sidx_q;
    ridx_d    = ridx_q;
    hidx_d    = hidx_q;
    gap_d     = gap_q;
    hadv_d    = 1'b0;
    cfgerr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (trigger_repetitions != '0 &&
              trigger_samples != '0) begin
            reps_d    = trigger_repetitions;
            samples_d = trigger_samples;
            hops_d    = (trig_generator_hops == '0) ?
                        ONE : trig_generator_hops;
            sidx_d    = '0;
            ridx_d    = '0;
            hidx_d    = '0;
            gap_d     = '0;
            state_d   = S_ARM;
          end else begin
            cfgerr_d = 1'b1;
          end
        end
      end
      S_ARM: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (sample_valid) begin
          if (sidx_q == samples_q - ONE) begin
            sidx_d = '0;
            gap_d  = '0;
            if (ridx_q < reps_q - ONE) begin
              ridx_d  = ridx_q + ONE;
              state_d = S_GAP;
            end else if (hidx_q < hops_q - ONE) begin
              ridx_d  = '0;
              hidx_d  = hidx_q + ONE;
              hadv_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              state_d = S_FINISH;
            end
          end else begin
            sidx_d = sidx_q + ONE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_ARM;
        end else begin
          gap_d = gap_q + ONE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort freezes the indices where they stand and suppresses done.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sidx_d  = sidx_q;
      ridx_d  = ridx_q;
      hidx_d  = hidx_q;
      gap_d   = '0;
      hadv_d  = 1'b0;
    end
  end

  assign trigger       = (state_q == S_ARM);
  assign record_active = (state_q == S_CAPTURE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign hop_advance   = hadv_q;
  assign cfg_error     = cfgerr_q;
  assign sample_index  = sidx_q;
  assign rep_index     = ridx_q;
  assign hop_index     = hidx_q;

endmodule
